// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding,
// geometry helpers and the byte-merge used by both write and bypass paths.
package regfile_pkg;

    localparam logic RF_CLEAR = 1'b0;
    localparam logic RF_RUN   = 1'b1;

    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int rf_nbytes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       enable);
        return enable ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: ready gating, hardwired-zero check and
// optional forwarding of the same-cycle write, merged byte by byte.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                    ready,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic [DATA_WIDTH-1:0]   entry,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wa,
    input  logic [DATA_WIDTH-1:0]   wd,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NBYTES = rf_nbytes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] merged;

    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
        assign merged[8*b +: 8] = merge_byte(entry[8*b +: 8], wd[8*b +: 8], wbe[b]);
    end

    // Zero register wins over bypass; bypass only once the file is usable.
    always_comb begin
        rdata = entry;
        if (!ready) begin
            rdata = '0;
        end else if (ZERO_REG && raddr == '0) begin
            rdata = '0;
        end else if (BYPASS && we && wa == raddr) begin
            rdata = merged;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-enabled writes and
// a clear sequencer that sweeps every entry after reset or init_req.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    NREAD      = 2,
    parameter bit                    ZERO_REG   = 1'b1,
    parameter bit                    BYPASS     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREAD*ADDR_WIDTH-1:0]   ra,
    output logic [NREAD*DATA_WIDTH-1:0]   rd,
    input  logic                          we,
    input  logic [ADDR_WIDTH-1:0]         wa,
    input  logic [DATA_WIDTH-1:0]         wd,
    input  logic [DATA_WIDTH/8-1:0]       wbe,
    input  logic                          init_req,
    output logic                          ready,
    output logic                          wr_drop
);

    localparam int DEPTH  = rf_depth(ADDR_WIDTH);
    localparam int NBYTES = rf_nbytes(DATA_WIDTH);

    logic                  state;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  sweep_last;
    logic [DATA_WIDTH-1:0] write_merged;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign sweep_last = (cnt == (ADDR_WIDTH+1)'(DEPTH - 1));
    assign ready      = (state == RF_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RF_CLEAR;
            cnt     <= '0;
            wr_drop <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (we) begin
                        wr_drop <= 1'b1;
                    end
                    if (sweep_last) begin
                        state <= RF_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + (ADDR_WIDTH+1)'(1);
                    end
                end
                default: begin
                    if (init_req) begin
                        state   <= RF_CLEAR;
                        cnt     <= '0;
                        wr_drop <= 1'b0;
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < NBYTES; b++) begin : g_wbyte
        assign write_merged[8*b +: 8] = merge_byte(mem[wa][8*b +: 8], wd[8*b +: 8], wbe[b]);
    end

    // The array has no reset; while reset is held nothing is written so an
    // interrupted write is lost and the following sweep clears the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == RF_CLEAR) begin
                mem[cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
            end else if (we && !(ZERO_REG && wa == '0)) begin
                mem[wa] <= write_merged;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        regfile_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) u_port (
            .ready(ready),
            .raddr(ra[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .entry(mem[ra[i*ADDR_WIDTH +: ADDR_WIDTH]]),
            .we   (we),
            .wa   (wa),
            .wd   (wd),
            .wbe  (wbe),
            .rdata(rd[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a default two-port bypassing instance alongside a
// four-port non-bypassing one, both driven from the same write port.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         reset;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [3:0]   wbe;
    logic         init_req;
    logic [9:0]   ra_a;
    logic [63:0]  rd_a;
    logic         ready_a;
    logic         drop_a;
    logic [19:0]  ra_b;
    logic [127:0] rd_b;
    logic         ready_b;
    logic         drop_b;

    int vectors    = 0;
    int miscompares = 0;
    int low_cycles;

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .clk(clk), .reset(reset), .ra(ra_a), .rd(rd_a), .we(we), .wa(wa),
        .wd(wd), .wbe(wbe), .init_req(init_req), .ready(ready_a), .wr_drop(drop_a)
    );

    regfile_mp #(.NREAD(4), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .ra(ra_b), .rd(rd_b), .we(we), .wa(wa),
        .wd(wd), .wbe(wbe), .init_req(init_req), .ready(ready_b), .wr_drop(drop_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] a,
                                 input logic [31:0] d, input logic [3:0] be);
        we  = w;
        wa  = a;
        wd  = d;
        wbe = be;
    endtask

    // Counts cycles with ready low, starting with the current one.
    task automatic countLow(output int n);
        n = 0;
        while (!ready_a && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        reset = 1'b0; init_req = 1'b0; ra_a = '0; ra_b = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0);
        step(); step();
        checkOutput("reset_ready_a", 128'(ready_a), 128'd0);
        checkOutput("reset_ready_b", 128'(ready_b), 128'd0);
        checkOutput("reset_drop", 128'(drop_a), 128'd0);
        checkOutput("reset_rd_gated", 128'(rd_a), 128'd0);

        reset = 1'b1;
        countLow(low_cycles);
        checkOutput("clear_low_cycles", 128'(low_cycles), 128'd32);
        checkOutput("clear_ready_b", 128'(ready_b), 128'd1);
        for (int a = 0; a < 32; a++) begin
            ra_a[4:0] = 5'(a);
            #1;
            checkOutput($sformatf("cleared_entry_%0d", a), 128'(rd_a[31:0]), 128'd0);
        end

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 4'b1111);
        step();
        applyStimulus(1'b1, 5'd5, 32'h00001234, 4'b0011);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0);
        ra_a = 10'd5; ra_b = 20'd5;
        #1;
        checkOutput("byte_write_a", 128'(rd_a[31:0]), 128'hDEAD1234);
        checkOutput("byte_write_b", 128'(rd_b[31:0]), 128'hDEAD1234);

        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111);
        ra_a = 10'd0;
        #1;
        checkOutput("zero_beats_bypass", 128'(rd_a[31:0]), 128'd0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        checkOutput("zero_reg_read", 128'(rd_a[31:0]), 128'd0);
        checkOutput("zero_reg_no_drop", 128'(drop_a), 128'd0);

        applyStimulus(1'b1, 5'd7, 32'h11111111, 4'b1111);
        step();
        applyStimulus(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101);
        ra_a = {5'd7, 5'd7}; ra_b = {10'd0, 5'd7, 5'd7};
        #1;
        checkOutput("bypass_on", 128'(rd_a), {64'd0, 32'h11BB11DD, 32'h11BB11DD});
        checkOutput("bypass_off_same", 128'(rd_b[63:0]), {64'd0, 32'h11111111, 32'h11111111});
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        checkOutput("bypass_off_next", 128'(rd_b[63:0]), {64'd0, 32'h11BB11DD, 32'h11BB11DD});
        checkOutput("bypass_on_next", 128'(rd_a), {64'd0, 32'h11BB11DD, 32'h11BB11DD});

        for (int a = 1; a <= 4; a++) begin
            applyStimulus(1'b1, 5'(a), 32'(a), 4'b1111);
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0);
        ra_b = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        checkOutput("four_ports", rd_b, {32'h4, 32'h3, 32'h2, 32'h1});
        ra_b = '0;
        #1;
        checkOutput("four_ports_zero", rd_b, 128'd0);

        init_req = 1'b1;
        step();
        init_req = 1'b0;
        checkOutput("init_ready_low", 128'(ready_a), 128'd0);
        ra_a = 10'd5;
        #1;
        checkOutput("clear_rd_gated", 128'(rd_a[31:0]), 128'd0);
        step();
        applyStimulus(1'b1, 5'd3, 32'h55, 4'b1111);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0);
        checkOutput("drop_set", 128'(drop_a), 128'd1);
        countLow(low_cycles);
        checkOutput("drop_sticky", 128'(drop_a), 128'd1);
        ra_a = 10'd3;
        #1;
        checkOutput("dropped_entry", 128'(rd_a[31:0]), 128'd0);

        init_req = 1'b1;
        step();
        init_req = 1'b0;
        checkOutput("init_clears_drop", 128'(drop_a), 128'd0);
        low_cycles = 0;
        while (!ready_a && low_cycles < 100) begin
            init_req = (low_cycles == 5);
            low_cycles++;
            step();
        end
        init_req = 1'b0;
        checkOutput("init_ignored_in_clear", 128'(low_cycles), 128'd32);

        init_req = 1'b1;
        step();
        init_req = 1'b0;
        applyStimulus(1'b1, 5'd9, 32'h1, 4'b1111);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0);
        for (int k = 0; k < 9; k++) step();
        checkOutput("pre_reset_drop", 128'(drop_a), 128'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_drop", 128'(drop_a), 128'd0);
        checkOutput("async_reset_ready", 128'(ready_a), 128'd0);
        step(); step();
        reset = 1'b1;
        countLow(low_cycles);
        checkOutput("resweep_cycles", 128'(low_cycles), 128'd32);

        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_run_ready", 128'(ready_a), 128'd0);
        step();
        reset = 1'b1;
        countLow(low_cycles);
        checkOutput("final_sweep_cycles", 128'(low_cycles), 128'd32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
